// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader controller.
// Covers frame geometry, word/address types and the loader state encoding.
package uart_loader_pkg;

    localparam int DATA_WID   = 32;
    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef logic [DATA_WID-1:0] addr_t;
    typedef logic [DATA_WID-1:0] data_t;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/uart_word_assembler.sv
// Collects bytes LSB-first into a 32-bit word.
// word_valid fires combinationally with the 4th byte, so the caller can register the word on that edge.
module uart_word_assembler
    import uart_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte,
    output data_t      o_word,
    output logic       o_word_valid,
    output logic [1:0] o_byte_idx
);

    logic [1:0] r_idx;
    data_t      r_shift;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx <= '0;
        end else if (i_byte_valid) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // NOTE: the shift register carries no reset; its contents are only consumed when o_word_valid qualifies them.
    always_ff @(posedge clk) begin
        if (i_byte_valid) begin
            r_shift <= {i_byte, r_shift[DATA_WID-1:8]};
        end
    end

    assign o_word       = {i_byte, r_shift[DATA_WID-1:8]};
    assign o_word_valid = i_byte_valid && (r_idx == 2'(WORD_BYTES - 1));
    assign o_byte_idx   = r_idx;

endmodule

// File: rtl/uart_boot_loader_ctrl.sv
// Parses a length-prefixed, XOR-checksummed UART frame and writes its words to memory.
// uart_done releases the CPU once a load completes or is skipped.
module uart_boot_loader_ctrl
    import uart_loader_pkg::*;
#(
    parameter addr_t BASE_ADDR      = 32'h0000_0000,
    parameter int    MAX_WORDS      = 16384,
    parameter int    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        start,
    input  logic        skip_load,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_data,
    output logic        uart_we,
    output logic        uart_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             r_state;
    state_e             w_next;
    data_t              r_len;
    logic [7:0]         r_chk;
    logic [TIMER_W-1:0] r_timer;
    addr_t              r_addr;
    data_t              r_data;
    logic               r_we;
    logic [15:0]        r_words;

    data_t      w_word;
    logic       w_word_valid;
    logic [1:0] w_byte_idx;
    logic       w_active;
    logic       w_skip;
    logic       w_accept;
    logic       w_asm_in;
    logic       w_counting;
    logic       w_timeout;
    logic       w_store;

    assign w_active   = (r_state == LEN) || (r_state == DATA) || (r_state == CHECK);
    assign w_skip     = (r_state == LEN) && skip_load && (w_byte_idx == 2'd0);
    // start wins over a coincident byte; skip wins over a byte arriving while armed.
    assign w_accept   = rx_valid && !start && w_active && !w_skip;
    assign w_asm_in   = w_accept && ((r_state == LEN) || (r_state == DATA));
    assign w_counting = ((r_state == LEN) && (w_byte_idx != 2'd0)) ||
                        (r_state == DATA) || (r_state == CHECK);
    assign w_timeout  = w_counting && !w_accept && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign w_store    = (r_state == DATA) && w_word_valid;

    uart_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (start || !w_active),
        .i_byte_valid (w_asm_in),
        .i_byte       (rx_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_idx   (w_byte_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LEN;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = LEN;
        end else begin
            case (r_state)
                LEN: begin
                    if (w_skip) begin
                        w_next = DONE;
                    end else if (w_timeout) begin
                        w_next = ERR;
                    end else if (w_word_valid) begin
                        w_next = ((w_word == '0) || (w_word > 32'(MAX_WORDS))) ? ERR : DATA;
                    end
                end
                DATA: begin
                    if (w_timeout) begin
                        w_next = ERR;
                    end else if (w_word_valid && (32'(r_words) == r_len - 32'd1)) begin
                        w_next = CHECK;
                    end
                end
                CHECK: begin
                    if (w_timeout) begin
                        w_next = ERR;
                    end else if (w_accept) begin
                        w_next = (rx_byte == r_chk) ? DONE : ERR;
                    end
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        uart_done    = (r_state == DONE);
        load_err     = (r_state == ERR);
        uart_addr    = r_addr;
        uart_data    = r_data;
        uart_we      = r_we;
        words_loaded = r_words;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len   <= '0;
            r_chk   <= '0;
            r_timer <= '0;
            r_addr  <= BASE_ADDR;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_words <= '0;
        end else begin
            r_we <= w_store;

            if ((r_state == LEN) && w_word_valid && (w_next == DATA)) begin
                r_len   <= w_word;
                r_words <= '0;
                r_chk   <= '0;
            end

            if ((r_state == DATA) && w_asm_in) begin
                r_chk <= r_chk ^ rx_byte;
            end

            // Address uses the pre-increment count; words_loaded steps on the same edge uart_we rises.
            if (w_store) begin
                r_data  <= w_word;
                r_addr  <= BASE_ADDR + addr_t'(r_words) * addr_t'(WORD_BYTES);
                r_words <= r_words + 16'd1;
            end

            if (start || w_accept || !w_counting) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Self-checking bench for uart_boot_loader_ctrl: frames are built from word lists and
// expected writes/outcomes come from a frame-level model (byte list, XOR, address = base + 4*i).
module tb_uart_boot_loader_ctrl;

    localparam logic [31:0] BASE      = 32'h0000_0100;
    localparam int          MAXW      = 16384;
    localparam int          TMO       = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        start;
    logic        skip_load;
    logic [31:0] uart_addr;
    logic [31:0] uart_data;
    logic        uart_we;
    logic        uart_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  tx_q[$];
    logic [63:0] exp_wr[$];
    logic [63:0] obs_wr[$];

    uart_boot_loader_ctrl #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .start        (start),
        .skip_load    (skip_load),
        .uart_addr    (uart_addr),
        .uart_data    (uart_data),
        .uart_we      (uart_we),
        .uart_done    (uart_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uart_we === 1'b1) obs_wr.push_back({uart_addr, uart_data});
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Model: length LSB-first, words LSB-first, XOR of payload; word k lands at BASE + 4*k.
    task automatic make_frame(input logic [31:0] w[$], input logic [7:0] bad_xor);
        logic [31:0] len;
        logic [7:0]  chk;
        logic [7:0]  b;
        len = 32'(w.size());
        chk = 8'h00;
        tx_q.delete();
        exp_wr.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(len[8*i +: 8]);
        for (int k = 0; k < w.size(); k++) begin
            for (int j = 0; j < 4; j++) begin
                b = w[k][8*j +: 8];
                tx_q.push_back(b);
                chk = chk ^ b;
            end
            exp_wr.push_back({BASE + 32'(4 * k), w[k]});
        end
        tx_q.push_back(chk ^ bad_xor);
    endtask

    task automatic load_frame(input string name, input logic [31:0] w[$],
                              input logic [7:0] bad_xor, input int max_gap);
        bit bad;
        bad = (bad_xor != 8'h00);
        make_frame(w, bad_xor);
        obs_wr.delete();
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
        n_checks++;
        if (obs_wr.size() !== exp_wr.size()) begin
            $display("FAIL %s write count: got %0d expected %0d", name, obs_wr.size(), exp_wr.size());
            n_fail++;
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                $display("FAIL %s write %0d addr/data: got %h expected %h", name, i, obs_wr[i], exp_wr[i]);
                n_fail++;
            end
        end
        n_checks++;
        if (words_loaded !== 16'(w.size())) begin
            $display("FAIL %s words_loaded: got %0d expected %0d", name, words_loaded, w.size());
            n_fail++;
        end
        n_checks++;
        if (uart_done !== !bad || load_err !== bad) begin
            $display("FAIL %s done/err: got %b/%b expected %b/%b", name, uart_done, load_err, !bad, bad);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({uart_addr, uart_data, uart_we, uart_done, load_err, words_loaded} !== {BASE, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            $display("FAIL reset values: got addr=%h data=%h we=%b done=%b err=%b words=%0d expected addr=%h zeros",
                     uart_addr, uart_data, uart_we, uart_done, load_err, words_loaded, BASE);
            n_fail++;
        end
    endtask

    task automatic test_normal_load();
        logic [31:0] w[$];
        w = '{32'h0000_0013, 32'h0010_0093};
        load_frame("normal", w, 8'h00, 0);
    endtask

    task automatic test_bad_checksum();
        logic [31:0] w[$];
        w = '{32'h0000_0013, 32'h0010_0093};
        pulse_start();
        load_frame("bad_chk", w, 8'h01, 1);
        pulse_start();
        load_frame("bad_chk_retry", w, 8'h00, 0);
    endtask

    task automatic test_length();
        logic [7:0] lens[3][4];
        logic       exp_err[3];
        lens    = '{'{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h01, 8'h40, 8'h00, 8'h00}, '{8'h00, 8'h40, 8'h00, 8'h00}};
        exp_err = '{1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            pulse_start();
            obs_wr.delete();
            for (int i = 0; i < 4; i++) send_byte(lens[t][i]);
            n_checks++;
            if (load_err !== exp_err[t] || uart_done !== 1'b0 || obs_wr.size() != 0) begin
                $display("FAIL length %0d: got err=%b done=%b writes=%0d expected err=%b done=0 writes=0",
                         t, load_err, uart_done, obs_wr.size(), exp_err[t]);
                n_fail++;
            end
        end
        pulse_start();
        n_checks++;
        if (load_err !== 1'b0 || uart_done !== 1'b0) begin
            $display("FAIL length abort: got err=%b done=%b expected 0/0", load_err, uart_done);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] hdr[5];
        hdr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13};
        pulse_start();
        foreach (hdr[i]) send_byte(hdr[i]);
        repeat (TMO - 1) @(negedge clk);
        n_checks++;
        if (load_err !== 1'b0) begin
            $display("FAIL timeout early: got err=%b after %0d idle expected 0", load_err, TMO - 1);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (load_err !== 1'b1) begin
            $display("FAIL timeout: got err=%b after %0d idle expected 1", load_err, TMO);
            n_fail++;
        end
        pulse_start();
        repeat (3 * TMO) @(negedge clk);
        n_checks++;
        if (load_err !== 1'b0 || uart_done !== 1'b0) begin
            $display("FAIL idle_len: got err=%b done=%b expected 0/0", load_err, uart_done);
            n_fail++;
        end
    endtask

    task automatic test_skip();
        logic [31:0] w[$];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs_wr.delete();
        skip_load = 1'b1;
        @(negedge clk);
        skip_load = 1'b0;
        n_checks++;
        if (uart_done !== 1'b1 || load_err !== 1'b0 || obs_wr.size() != 0) begin
            $display("FAIL skip: got done=%b err=%b writes=%0d expected 1/0/0", uart_done, load_err, obs_wr.size());
            n_fail++;
        end
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        n_checks++;
        if (uart_done !== 1'b1 || words_loaded !== 16'd0) begin
            $display("FAIL done_ignores_rx: got done=%b words=%0d expected 1/0", uart_done, words_loaded);
            n_fail++;
        end
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h05;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        n_checks++;
        if (uart_done !== 1'b0 || load_err !== 1'b0) begin
            $display("FAIL start_rearm: got done=%b err=%b expected 0/0", uart_done, load_err);
            n_fail++;
        end
        send_byte(8'h01);
        skip_load = 1'b1;
        @(negedge clk);
        skip_load = 1'b0;
        n_checks++;
        if (uart_done !== 1'b0) begin
            $display("FAIL skip_mid_len: got done=%b expected 0", uart_done);
            n_fail++;
        end
        pulse_start();
        w = '{32'($urandom), 32'($urandom), 32'($urandom)};
        load_frame("after_rearm", w, 8'h00, 2);
    endtask

    task automatic test_reset_mid_data();
        logic [31:0] w[$];
        pulse_start();
        w = '{32'($urandom), 32'($urandom)};
        make_frame(w, 8'h00);
        for (int i = 0; i < 10; i++) send_byte(tx_q[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({uart_addr, uart_data, uart_we, uart_done, load_err, words_loaded} !== {BASE, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            $display("FAIL mid_data_reset: got addr=%h data=%h we=%b done=%b err=%b words=%0d expected addr=%h zeros",
                     uart_addr, uart_data, uart_we, uart_done, load_err, words_loaded, BASE);
            n_fail++;
        end
        w = '{32'($urandom), 32'($urandom)};
        load_frame("post_reset", w, 8'h00, 1);
    endtask

    task automatic test_random_frames();
        logic [31:0] w[$];
        logic [7:0]  bx;
        for (int it = 0; it < 8; it++) begin
            pulse_start();
            w.delete();
            repeat ($urandom_range(6, 1)) w.push_back(32'($urandom));
            bx = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            load_frame($sformatf("random%0d", it), w, bx, $urandom_range(3, 0));
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        start     = 1'b0;
        skip_load = 1'b0;
        @(negedge clk);
        test_reset();
        test_normal_load();
        test_bad_checksum();
        test_length();
        test_timeout();
        test_skip();
        test_reset_mid_data();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
